frame_sync_ctrl: RTL and testbench
==================================

Name: frame_sync_ctrl

Overview:
- Frame-synchronisation and lane-scheduling controller for the serial converter datapath.
- Hunts the bit-serial DIN stream for the 10-bit sync word and qualifies lock over consecutive frames. Flywheels through isolated sync misses.
- While locked, emits per-word strobes with word index and payload. Tells the downstream lane writer which output lane (A/B/C) and which buffer read order apply, per the frame's MODE.

Parameters:
- SYNC_WORD, 10'h3FF, frame sync pattern, MSB received first.
- FRAME_WORDS, 90, 10-bit payload words per frame after the sync word.
- LOCK_CNT, 2, consecutive on-time syncs needed in VERIFY before LOCK.
- MISS_MAX, 3, consecutive missed syncs in FLYWHEEL before returning to HUNT.

Ports:
- CLK_30MHZ  in  1  bit clock; DIN sampled on the rising edge.
- RST  in  1  asynchronous, active-low reset.
- DIN  in  1  serial data, MSB first.
- MODE  in  2  0/1: lanes A,B, forward/reverse; 2/3: lanes A,B,C, forward/reverse.
- LOCKED  out  1  high in LOCK and FLYWHEEL.
- FRAME_START  out  1  one-cycle pulse on each accepted or flywheeled sync.
- WORD_STB  out  1  one-cycle pulse, payload word complete.
- WORD_IDX  out  7  word index 0..FRAME_WORDS-1, valid with WORD_STB.
- WORD_DATA  out  10  completed word, valid with WORD_STB.
- LANE_SEL  out  2  0=A, 1=B, 2=C, valid with WORD_STB; 3 = skip (zero payload).
- REVERSE  out  1  frame's latched MODE[0]; downstream reads the buffer at FRAME_WORDS-1-idx.
- SYNC_ERR_CNT  out  16  sync-miss counter; see Optional Feature.

Behaviour:
- Reset (async, RST=0): state=HUNT; shift register, pos, match/miss counters, lane pointer, mode_q all 0. Every output 0.
- Shift: sr_next = {sr[8:0], DIN} every cycle; sr <= sr_next.
- pos: counts bits since the last sync end, 0..(FRAME_WORDS+1)*10-1 (909 at default); pos_next = pos+1.
- HUNT: sr_next == SYNC_WORD → VERIFY, pos<=0, match_cnt<=1. No WORD_STB and no FRAME_START in HUNT.
- Sync check point: pos_next == (FRAME_WORDS+1)*10. The sync check is done in every non-HUNT state; pos<=0 at every check. hit = (sr_next == SYNC_WORD).
- VERIFY:
  - hit: match_cnt+1. If that reaches LOCK_CNT → LOCK and pulse FRAME_START.
  - miss: → HUNT.
  - No word strobes in VERIFY.
- LOCK:
  - hit: pulse FRAME_START.
  - miss: → FLYWHEEL, miss_cnt<=1, pulse FRAME_START at the assumed position.
- FLYWHEEL:
  - hit: → LOCK, miss_cnt<=0.
  - miss: miss_cnt+1. Reaching MISS_MAX → HUNT, LOCKED drops the next cycle, no FRAME_START. Otherwise pulse FRAME_START.
- Words (LOCK/FLYWHEEL only): when pos_next = 10*(k+1) for k < FRAME_WORDS, WORD_STB=1 next cycle with WORD_IDX=k and WORD_DATA=sr_next. All outputs are registered, one cycle latency.
- Scheduling:
  - MODE is latched to mode_q on each FRAME_START, so a change takes effect only at the next frame.
  - The lane pointer resets to A on FRAME_START.
  - If WORD_DATA[9:2]==0: LANE_SEL=3 and the pointer holds.
  - Otherwise LANE_SEL = pointer, then the pointer advances: A→B→A for mode_q<2; A→B→C→A for mode_q≥2.
  - REVERSE = mode_q[0].
- The sync word is never reported as a payload word. Sync-like payload words do not affect LOCK; lock follows frame timing only.
- Reset mid-frame: immediate return to HUNT; any pulse in flight is cleared.

Optional Feature:
- SYNC_ERR_CNT_EN defined: SYNC_ERR_CNT increments, saturating at 16'hFFFF, on every missed sync check in LOCK/FLYWHEEL. It is cleared only by reset.
- Undefined: SYNC_ERR_CNT is tied to 0 and no counter is built.

Test Plan:
- Reset then three clean frames, MODE=0, payload words 8'h01.. → LOCKED rises after the 2nd sync. 90 WORD_STB per frame, IDX 0..89, LANE_SEL alternating 0,1,0,1, REVERSE=0.
- MODE=2, payload with words 3 and 7 having [9:2]=0 → LANE_SEL=3 at IDX 3 and 7. Nonzero words rotate 0,1,2 without a gap.
- Locked, corrupt one sync word → FLYWHEEL. FRAME_START still pulses, words continue, back to LOCK at the next good sync. With the macro, SYNC_ERR_CNT=1.
- Locked, corrupt three consecutive syncs → LOCKED=0 one cycle after the 3rd check, no WORD_STB until re-lock. Macro: SYNC_ERR_CNT=3.
- MODE changed 3→1 mid-frame → LANE_SEL keeps the 3-lane rotation and REVERSE=1 until the next FRAME_START, then the 2-lane rotation.
- Assert RST at word 45 while locked → all outputs 0 immediately; re-lock takes two clean syncs.

Source files
------------

// File: rtl/frame_sync_ctrl.sv
// Serial frame-sync hunter, lock qualifier and per-word lane scheduler.
// Define SYNC_ERR_CNT_EN to build the saturating sync-miss counter.
module frame_sync_ctrl #(
    parameter logic [9:0] SYNC_WORD   = 10'h3FF,
    parameter int         FRAME_WORDS = 90,
    parameter int         LOCK_CNT    = 2,
    parameter int         MISS_MAX    = 3
) (
    input  logic        CLK_30MHZ,
    input  logic        RST,
    input  logic        DIN,
    input  logic [1:0]  MODE,
    output logic        LOCKED,
    output logic        FRAME_START,
    output logic        WORD_STB,
    output logic [6:0]  WORD_IDX,
    output logic [9:0]  WORD_DATA,
    output logic [1:0]  LANE_SEL,
    output logic        REVERSE,
    output logic [15:0] SYNC_ERR_CNT
);

    typedef enum logic [1:0] {S_HUNT, S_VERIFY, S_LOCK, S_FLY} state_t;

    localparam logic [6:0] LAST_WORD = 7'(FRAME_WORDS);
    localparam logic [3:0] LOCK_N    = 4'(LOCK_CNT);
    localparam logic [3:0] MISS_N    = 4'(MISS_MAX);

    state_t      r_state;
    state_t      w_state_next;
    logic [9:0]  r_sr;
    logic [9:0]  w_sr_next;
    logic [3:0]  r_bit_cnt;
    logic [6:0]  r_word_cnt;
    logic [3:0]  r_match_cnt;
    logic [3:0]  r_miss_cnt;
    logic [3:0]  w_match_next;
    logic [3:0]  w_miss_next;
    logic [1:0]  r_lane_ptr;
    logic [1:0]  w_lane_adv;
    logic [1:0]  r_mode_q;
    logic        r_locked;
    logic        r_fs;
    logic        r_stb;
    logic [6:0]  r_idx;
    logic [9:0]  r_data;
    logic [1:0]  r_lane;
    logic        w_hit;
    logic        w_bit_done;
    logic        w_check;
    logic        w_word;
    logic        w_fs;
    logic        w_locked_next;
    logic        w_skip;
    logic        w_tracking;

    assign w_sr_next  = {r_sr[8:0], DIN};
    assign w_hit      = (w_sr_next == SYNC_WORD);
    assign w_tracking = (r_state == S_LOCK) || (r_state == S_FLY);
    // bit/word counters together stand for the bit position since sync end
    assign w_bit_done = (r_bit_cnt == 4'd9);
    assign w_check    = (r_state != S_HUNT) && w_bit_done
                        && (r_word_cnt == LAST_WORD);
    assign w_word     = w_tracking && w_bit_done
                        && (r_word_cnt != LAST_WORD);
    assign w_skip     = (w_sr_next[9:2] == 8'd0);
    assign w_lane_adv = ((r_lane_ptr == 2'd1 && !r_mode_q[1])
                        || r_lane_ptr == 2'd2) ? 2'd0
                        : r_lane_ptr + 2'd1;

    always_ff @(posedge CLK_30MHZ or negedge RST) begin
        if (!RST) begin
            r_state     <= S_HUNT;
            r_match_cnt <= 4'd0;
            r_miss_cnt  <= 4'd0;
        end else begin
            r_state     <= w_state_next;
            r_match_cnt <= w_match_next;
            r_miss_cnt  <= w_miss_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_match_next = r_match_cnt;
        w_miss_next  = r_miss_cnt;
        unique case (r_state)
            S_HUNT: begin
                w_miss_next = 4'd0;
                if (w_hit) begin
                    w_state_next = S_VERIFY;
                    w_match_next = 4'd1;
                end
            end
            S_VERIFY: begin
                if (w_check) begin
                    if (!w_hit) begin
                        w_state_next = S_HUNT;
                    end else begin
                        w_match_next = r_match_cnt + 4'd1;
                        if (w_match_next >= LOCK_N)
                            w_state_next = S_LOCK;
                    end
                end
            end
            S_LOCK: begin
                if (w_check && !w_hit) begin
                    w_state_next = S_FLY;
                    w_miss_next  = 4'd1;
                end
            end
            S_FLY: begin
                if (w_check) begin
                    if (w_hit) begin
                        w_state_next = S_LOCK;
                        w_miss_next  = 4'd0;
                    end else begin
                        w_miss_next = r_miss_cnt + 4'd1;
                        if (w_miss_next >= MISS_N)
                            w_state_next = S_HUNT;
                    end
                end
            end
        endcase
    end

    // a sync check that leaves us tracking is an accepted or flywheeled sync
    always_comb begin
        w_locked_next = (w_state_next == S_LOCK) || (w_state_next == S_FLY);
        w_fs          = w_check && w_locked_next;
    end

    always_ff @(posedge CLK_30MHZ or negedge RST) begin
        if (!RST) begin
            r_sr       <= 10'd0;
            r_bit_cnt  <= 4'd0;
            r_word_cnt <= 7'd0;
            r_lane_ptr <= 2'd0;
            r_mode_q   <= 2'd0;
            r_locked   <= 1'b0;
            r_fs       <= 1'b0;
            r_stb      <= 1'b0;
            r_idx      <= 7'd0;
            r_data     <= 10'd0;
            r_lane     <= 2'd0;
        end else begin
            r_sr     <= w_sr_next;
            r_locked <= w_locked_next;
            r_fs     <= w_fs;
            r_stb    <= w_word;
            if (r_state == S_HUNT || w_check) begin
                r_bit_cnt  <= 4'd0;
                r_word_cnt <= 7'd0;
            end else if (w_bit_done) begin
                r_bit_cnt  <= 4'd0;
                r_word_cnt <= r_word_cnt + 7'd1;
            end else begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end
            if (w_word) begin
                r_idx  <= r_word_cnt;
                r_data <= w_sr_next;
                r_lane <= w_skip ? 2'd3 : r_lane_ptr;
            end
            if (w_fs) begin
                r_mode_q   <= MODE;
                r_lane_ptr <= 2'd0;
            end else if (w_word && !w_skip) begin
                r_lane_ptr <= w_lane_adv;
            end
        end
    end

`ifdef SYNC_ERR_CNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge CLK_30MHZ or negedge RST) begin
        if (!RST)
            r_err_cnt <= 16'd0;
        else if (w_check && !w_hit && w_tracking
                 && r_err_cnt != 16'hFFFF)
            r_err_cnt <= r_err_cnt + 16'd1;
    end

    assign SYNC_ERR_CNT = r_err_cnt;
`else
    assign SYNC_ERR_CNT = 16'd0;
`endif

    assign LOCKED      = r_locked;
    assign FRAME_START = r_fs;
    assign WORD_STB    = r_stb;
    assign WORD_IDX    = r_idx;
    assign WORD_DATA   = r_data;
    assign LANE_SEL    = r_lane;
    assign REVERSE     = r_mode_q[0];

endmodule

// File: tb/tb_frame_sync_ctrl.sv
// Randomised scoreboard bench for frame_sync_ctrl against a bit-level
// reference model of the framing, lock and lane rules.
module tb_frame_sync_ctrl;

    localparam logic [9:0] SYNC  = 10'h3FF;
    localparam int         NW    = 90;
    localparam int         FBITS = (NW + 1) * 10;
    localparam int         LOCKN = 2;
    localparam int         MISSN = 3;

    localparam int P_SEARCH  = 0;
    localparam int P_CONFIRM = 1;
    localparam int P_TRACK   = 2;
    localparam int P_COAST   = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        din = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [1:0]  cur_mode = 2'd0;
    logic        locked;
    logic        frame_start;
    logic        word_stb;
    logic [6:0]  word_idx;
    logic [9:0]  word_data;
    logic [1:0]  lane_sel;
    logic        reverse;
    logic [15:0] sync_err_cnt;

    frame_sync_ctrl dut (
        .CLK_30MHZ    (clk),
        .RST          (rst),
        .DIN          (din),
        .MODE         (mode),
        .LOCKED       (locked),
        .FRAME_START  (frame_start),
        .WORD_STB     (word_stb),
        .WORD_IDX     (word_idx),
        .WORD_DATA    (word_data),
        .LANE_SEL     (lane_sel),
        .REVERSE      (reverse),
        .SYNC_ERR_CNT (sync_err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         tag;
        int         idx;
        logic [9:0] data;
        logic [1:0] lane;
        logic       rev;
    } wexp_t;

    typedef struct {
        int   tag;
        logic val;
    } lexp_t;

    wexp_t wq[$];
    int    fq[$];
    lexp_t lq[$];

    int cyc     = 0;
    int n_tests = 0;
    int n_fail  = 0;

    int         m_phase;
    logic [9:0] m_hist;
    int         m_pos;
    int         m_matches;
    int         m_misses;
    int         m_errs;
    logic [1:0] m_mode;
    int         m_ptr;
    logic       m_locked;
    logic       prev_l = 1'b0;

    function automatic void model_reset(input int tag);
        if (m_locked) lq.push_back('{tag, 1'b0});
        m_phase   = P_SEARCH;
        m_hist    = 10'd0;
        m_pos     = 0;
        m_matches = 0;
        m_misses  = 0;
        m_errs    = 0;
        m_mode    = 2'd0;
        m_ptr     = 0;
        m_locked  = 1'b0;
    endfunction

    function automatic void model_bit(input logic b, input int tag);
        logic       fs;
        logic       hit;
        logic       nl;
        logic [1:0] lane;
        int         k;
        fs     = 1'b0;
        m_hist = {m_hist[8:0], b};
        if (m_phase == P_SEARCH) begin
            if (m_hist == SYNC) begin
                m_phase   = P_CONFIRM;
                m_pos     = 0;
                m_matches = 1;
            end
        end else begin
            m_pos++;
            if (m_pos == FBITS) begin
                m_pos = 0;
                hit   = (m_hist == SYNC);
                case (m_phase)
                    P_CONFIRM: begin
                        if (!hit) m_phase = P_SEARCH;
                        else begin
                            m_matches++;
                            if (m_matches >= LOCKN) begin
                                m_phase = P_TRACK;
                                fs = 1'b1;
                            end
                        end
                    end
                    P_TRACK: begin
                        fs = 1'b1;
                        if (!hit) begin
                            m_phase  = P_COAST;
                            m_misses = 1;
                            if (m_errs < 65535) m_errs++;
                        end
                    end
                    default: begin
                        if (hit) begin
                            m_phase  = P_TRACK;
                            m_misses = 0;
                            fs = 1'b1;
                        end else begin
                            m_misses++;
                            if (m_errs < 65535) m_errs++;
                            if (m_misses >= MISSN) m_phase = P_SEARCH;
                            else fs = 1'b1;
                        end
                    end
                endcase
                if (fs) begin
                    fq.push_back(tag);
                    m_mode = mode;
                    m_ptr  = 0;
                end
            end else if (m_pos % 10 == 0 && m_phase >= P_TRACK) begin
                k = m_pos / 10 - 1;
                if (m_hist[9:2] == 8'd0) begin
                    lane = 2'd3;
                end else begin
                    lane  = 2'(m_ptr);
                    m_ptr = (m_ptr + 1) % ((m_mode >= 2'd2) ? 3 : 2);
                end
                wq.push_back('{tag, k, m_hist, lane, m_mode[0]});
            end
        end
        nl = (m_phase >= P_TRACK);
        if (nl != m_locked) begin
            lq.push_back('{tag, nl});
            m_locked = nl;
        end
    endfunction

    task automatic fail_line(input string name, input string got,
                             input string req);
        n_fail++;
        $display("FAIL %s cyc=%0d got %s required %s", name, cyc, got, req);
    endtask

    task automatic chk(input string name, input int got, input int req);
        n_tests++;
        if (got != req)
            fail_line(name, $sformatf("%0d", got), $sformatf("%0d", req));
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows an event
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (fq.size() > 0 && fq[0] < cyc)
                fail_line("frame_start_missing", "none",
                          $sformatf("pulse@%0d", fq.pop_front()));
            if (wq.size() > 0 && wq[0].tag < cyc)
                fail_line("word_stb_missing", "none",
                          $sformatf("idx%0d@%0d", wq[0].idx, wq.pop_front().tag));
            if (lq.size() > 0 && lq[0].tag < cyc)
                fail_line("locked_missing", "none",
                          $sformatf("edge@%0d", lq.pop_front().tag));
            if (frame_start) begin
                n_tests++;
                if (fq.size() == 0) fail_line("frame_start", "pulse", "none");
                else if (fq[0] != cyc)
                    fail_line("frame_start", $sformatf("@%0d", cyc),
                              $sformatf("@%0d", fq.pop_front()));
                else void'(fq.pop_front());
            end
            if (word_stb) begin
                n_tests++;
                if (wq.size() == 0) begin
                    fail_line("word_stb", "strobe", "none");
                end else begin
                    wexp_t e;
                    e = wq.pop_front();
                    if (e.tag != cyc || e.idx != int'(word_idx)
                        || e.data != word_data || e.lane != lane_sel
                        || e.rev != reverse)
                        fail_line("word",
                          $sformatf("@%0d idx%0d d%h ln%0d rv%0d", cyc,
                                    word_idx, word_data, lane_sel, reverse),
                          $sformatf("@%0d idx%0d d%h ln%0d rv%0d", e.tag,
                                    e.idx, e.data, e.lane, e.rev));
                end
            end
            if (locked != prev_l) begin
                n_tests++;
                if (lq.size() == 0) begin
                    fail_line("locked", $sformatf("%0d", locked), "no edge");
                end else begin
                    lexp_t l;
                    l = lq.pop_front();
                    if (l.tag != cyc || l.val != locked)
                        fail_line("locked",
                                  $sformatf("%0d@%0d", locked, cyc),
                                  $sformatf("%0d@%0d", l.val, l.tag));
                end
            end
            prev_l = locked;
        end
    end

    task automatic drive_bit(input logic b);
        @(negedge clk);
        mode = cur_mode;
        din  = b;
        model_bit(b, cyc + 1);
    endtask

    task automatic send_word(input logic [9:0] w);
        for (int i = 9; i >= 0; i--) drive_bit(w[i]);
    endtask

    function automatic logic [9:0] payload(input int kind, input int k);
        if (kind == 0) return {8'(k + 1), 2'b00};
        if (kind == 1) begin
            if (k == 3 || k == 7) return 10'($urandom_range(0, 3));
            return {8'($urandom_range(1, 255)), 2'($urandom_range(0, 3))};
        end
        if ($urandom_range(0, 7) == 0) return 10'($urandom_range(0, 3));
        return 10'($urandom);
    endfunction

    task automatic send_frame(input logic good, input int kind,
                              input int n_words, input int chg_at,
                              input logic [1:0] chg_mode);
        logic [9:0] s;
        logic [9:0] one;
        one = 10'd1;
        s   = good ? SYNC : (SYNC ^ (one << $urandom_range(0, 9)));
        send_word(s);
        for (int k = 0; k < n_words; k++) begin
            if (k == chg_at) cur_mode = chg_mode;
            send_word(payload(kind, k));
        end
    endtask

    task automatic check_zero(input string tagname);
        chk({tagname, "_locked"}, int'(locked), 0);
        chk({tagname, "_fs"}, int'(frame_start), 0);
        chk({tagname, "_stb"}, int'(word_stb), 0);
        chk({tagname, "_idx"}, int'(word_idx), 0);
        chk({tagname, "_data"}, int'(word_data), 0);
        chk({tagname, "_lane"}, int'(lane_sel), 0);
        chk({tagname, "_rev"}, int'(reverse), 0);
        chk({tagname, "_err"}, int'(sync_err_cnt), 0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst  = 1'b1;
        mode = cur_mode;
        din  = 1'b0;
        model_bit(1'b0, cyc + 1);
    endtask

    function automatic int exp_err();
`ifdef SYNC_ERR_CNT_EN
        return m_errs;
`else
        return 0;
`endif
    endfunction

    initial begin
        model_reset(0);
        repeat (3) @(negedge clk);
        check_zero("reset");
        release_reset();
        for (int i = 0; i < 23; i++) drive_bit(1'($urandom_range(0, 1)));

        for (int f = 0; f < 3; f++) send_frame(1'b1, 0, NW, -1, 2'd0);
        cur_mode = 2'd2;
        for (int f = 0; f < 2; f++) send_frame(1'b1, 1, NW, -1, 2'd0);

        send_frame(1'b0, 2, NW, -1, 2'd0);
        send_frame(1'b1, 2, NW, -1, 2'd0);
        send_frame(1'b1, 2, NW, -1, 2'd0);
        chk("err_after_one_miss", int'(sync_err_cnt), exp_err());

        cur_mode = 2'd3;
        send_frame(1'b1, 2, NW, -1, 2'd0);
        send_frame(1'b1, 2, NW, 40, 2'd1);
        send_frame(1'b1, 2, NW, -1, 2'd0);

        for (int f = 0; f < 3; f++) send_frame(1'b0, 2, NW, -1, 2'd0);
        for (int f = 0; f < 4; f++) send_frame(1'b1, 2, NW, -1, 2'd0);
        chk("err_after_three_miss", int'(sync_err_cnt), exp_err());

        send_frame(1'b1, 2, 45, -1, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset(cyc + 1);
        #1;
        check_zero("midreset");
        repeat (2) @(negedge clk);
        release_reset();
        for (int f = 0; f < 3; f++) send_frame(1'b1, 2, NW, -1, 2'd0);

        for (int f = 0; f < 8; f++) begin
            cur_mode = 2'($urandom_range(0, 3));
            send_frame($urandom_range(0, 3) != 0, 2, NW,
                       int'($urandom_range(0, 120)),
                       2'($urandom_range(0, 3)));
        end
        send_word(SYNC);
        for (int i = 0; i < 5; i++) drive_bit(1'b0);
        repeat (3) @(negedge clk);

        chk("err_final", int'(sync_err_cnt), exp_err());
        chk("fq_empty", fq.size(), 0);
        chk("wq_empty", wq.size(), 0);
        chk("lq_empty", lq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
